// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one add/sub slice and a carry
// flop process one operand bit per clock, LSB first.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             sel_q;
  logic             c;

  logic             bx;
  logic             sum_bit;
  logic             c_nxt;
  logic [WIDTH-1:0] r_nxt;

  assign bx      = b_sr[0] ^ sel_q;
  assign sum_bit = a_sr[0] ^ bx ^ c;
  assign c_nxt   = (a_sr[0] & bx) | (a_sr[0] & c) | (bx & c);
  assign r_nxt   = {sum_bit, r_sr[WIDTH-1:1]};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cnt      <= '0;
      sel_q    <= 1'b0;
      c        <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            sel_q <= sel;
            c     <= sel;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_nxt;
          c    <= c_nxt;
          cnt  <= cnt + 1'b1;
          // c here is the carry into the MSB slice
          if (cnt == LAST) begin
            result   <= r_nxt;
            cout     <= c_nxt;
            overflow <= c ^ c_nxt;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: expectations queued at start,
// checked when done pulses.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .sel(sel),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .cout(cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_run = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s, input int e0);
    exp_t m;
    logic [W-1:0] yy;
    logic [W:0]   f;
    yy    = s ? ~y : y;
    f     = {1'b0, x} + {1'b0, yy} + (W+1)'(s);
    m.r   = f[W-1:0];
    m.co  = f[W];
    m.ov  = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    m.cyc = e0 + W;
    return m;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        done_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.r);
          chk("cout", cout, e.co);
          chk("overflow", overflow, e.ov);
          chk("latency", cyc, e.cyc);
          chk("busy_len", busy_run, W);
        end
        busy_run = 0;
      end
    end
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic s);
    start = 1'b1;
    a     = x;
    b     = y;
    sel   = s;
    @(posedge clk);
    @(negedge clk);
    sb.push_back(model(x, y, s, cyc));
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sel   = $urandom_range(0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [W-1:0] tv_a  [6] = '{8'h35, 8'h7F, 8'hFF, 8'h10, 8'h80, 8'h55};
  logic [W-1:0] tv_b  [6] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01, 8'h55};
  logic         tv_s  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [W-1:0] tv_r  [6] = '{8'h7F, 8'h80, 8'h00, 8'hF0, 8'h7F, 8'h00};
  logic         tv_co [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic         tv_ov [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      op(tv_a[i], tv_b[i], tv_s[i]);
      wait_done();
      chk("tv_result", result, tv_r[i]);
      chk("tv_cout", cout, tv_co[i]);
      chk("tv_ovf", overflow, tv_ov[i]);
      repeat (3) @(negedge clk);
      chk("idle_hold", result, tv_r[i]);
    end

    d0 = done_cnt;
    op(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    sel   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("ignored_start", result, 8'h46);
    repeat (12) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);

    op(8'h20, 8'h22, 1'b0);
    wait_done();
    op(8'h01, 8'h02, 1'b0);
    chk("b2b_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("b2b_hold", result, 8'h42);
    wait_done();
    chk("b2b_result", result, 8'h03);
    repeat (2) @(negedge clk);

    d0 = done_cnt;
    op(8'h11, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    op(8'h0F, 8'h01, 1'b0);
    wait_done();
    chk("post_rst_result", result, 8'h10);
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Multi-cycle, bit-serial WIDTH-bit adder/subtractor.
- One single-bit add/sub datapath slice plus a carry flip-flop processes one operand bit per clock, LSB first.
- Parallel operands are loaded, shifted through the slice, and reassembled into a parallel result.
- Sits beside the combinational single-bit add/sub cells in the lab datapath as the area-minimal sequential alternative to a ripple array, with a start/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request an operation; sampled on rising edge in IDLE or DONE only
- sel  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: result/cout/overflow valid and updated
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- cout  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - Internal shift registers, bit counter and carry flip-flop cleared.
  - Reset mid-operation aborts it; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 at edge E0:
  - Capture a, b, sel into shift registers.
  - Carry flip-flop <= sel (the +1 for two's-complement subtraction).
  - Counter <= 0; state -> RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each edge:
  - bit = a_sr[0] ^ (b_sr[0] ^ sel_q) ^ c.
  - c <= majority(a_sr[0], b_sr[0]^sel_q, c).
  - a_sr/b_sr shift right.
  - Result shift register shifts right with bit inserted at MSB.
  - Counter increments.
  - Carry into the MSB is recorded on the edge where counter == WIDTH-1.
- RUN, final edge (counter == WIDTH-1, edge E0+WIDTH):
  - result <= completed shift register contents including this bit.
  - cout <= new carry.
  - overflow <= carry_into_MSB ^ new carry.
  - state -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless start re-triggers (same rules as IDLE).
- Latency: done high during the cycle following edge E0+WIDTH.
  - Back-to-back throughput: one operation per WIDTH+1 cycles.
- start while in RUN is ignored; captured operands are unaffected by changes on a/b/sel after E0.
- result, cout and overflow hold their last values through RUN/IDLE and change only on the final RUN edge or reset.
- busy is a registered state decode: 1 exactly in RUN, WIDTH cycles per operation.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1 is ever used.

Test Plan:
- WIDTH=8, add 0x35+0x4A -> result=0x7F, cout=0, overflow=0, done exactly 8 edges after start edge, busy high 8 cycles.
- Add 0x7F+0x01 -> 0x80, cout=0, overflow=1; add 0xFF+0x01 -> 0x00, cout=1, overflow=0.
- Sub 0x10-0x20 -> 0xF0, cout=0, overflow=0; sub 0x80-0x01 -> 0x7F, cout=1, overflow=1; sub 0x55-0x55 -> 0x00, cout=1.
- Pulse start again at cycle 3 of RUN with different a/b/sel -> ignored, first result unchanged, single done pulse.
- Start asserted in the DONE cycle with 0x01+0x02 -> new operation accepted, result=0x03 done 9 cycles after previous done; prior result held until then.
- reset_n low at RUN cycle 4 -> all outputs 0 immediately (async), no done pulse; subsequent start of 0x0F+0x01 -> 0x10.
